// File: rtl/updown_credit_counter.sv
// Multi-channel saturating up/down credit counter with programmable watermark flags
// and sticky overflow/underflow per channel.
module updown_credit_counter_ch #(
  parameter int RANGE     = 16,
  parameter int STEP_W    = 3,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int INIT_VAL  = 0,
  parameter int CW        = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [STEP_W-1:0] up_amt,
  input  logic [STEP_W-1:0] down_amt,
  input  logic              ch_clr,
  input  logic              err_clr,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              ovf,
  output logic              udf
);
  localparam int NW = CW + STEP_W + 1;
  localparam logic signed [NW-1:0] RANGE_S = NW'(RANGE);
  localparam logic [CW-1:0] RANGE_C  = CW'(RANGE);
  localparam logic [CW-1:0] INIT_C   = CW'(INIT_VAL);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic signed [NW-1:0] nxt;
  logic                 over, under;

  // Wide signed sum so up and down net out before saturation is judged.
  always_comb begin
    nxt   = $signed({{(STEP_W+1){1'b0}}, count})
          + $signed({{(CW+1){1'b0}}, up_amt})
          - $signed({{(CW+1){1'b0}}, down_amt});
    under = nxt[NW-1];
    over  = !under && (nxt > RANGE_S);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= INIT_C;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (ch_clr)     count <= INIT_C;
      else if (over)  count <= RANGE_C;
      else if (under) count <= '0;
      else            count <= nxt[CW-1:0];
      // A fresh error outranks err_clr; a clear cycle never raises errors.
      if (!ch_clr && over) ovf <= 1'b1;
      else if (err_clr)    ovf <= 1'b0;
      if (!ch_clr && under) udf <= 1'b1;
      else if (err_clr)     udf <= 1'b0;
    end
  end

  assign full         = (count == RANGE_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
endmodule

module updown_credit_counter #(
  parameter int NUM_CH    = 4,
  parameter int RANGE     = 16,
  parameter int STEP_W    = 3,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int INIT_VAL  = 0,
  localparam int CW       = $clog2(RANGE + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH*STEP_W-1:0] up_amt,
  input  logic [NUM_CH*STEP_W-1:0] down_amt,
  input  logic [NUM_CH-1:0]        ch_clr,
  input  logic [NUM_CH-1:0]        err_clr,
  output logic [NUM_CH*CW-1:0]     count,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH-1:0]        almost_full,
  output logic [NUM_CH-1:0]        almost_empty,
  output logic [NUM_CH-1:0]        ovf,
  output logic [NUM_CH-1:0]        udf
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    updown_credit_counter_ch #(
      .RANGE(RANGE), .STEP_W(STEP_W), .AFULL_TH(AFULL_TH),
      .AEMPTY_TH(AEMPTY_TH), .INIT_VAL(INIT_VAL), .CW(CW)
    ) u_ch (
      .clk         (clk),
      .rstn        (rstn),
      .up_amt      (up_amt[i*STEP_W +: STEP_W]),
      .down_amt    (down_amt[i*STEP_W +: STEP_W]),
      .ch_clr      (ch_clr[i]),
      .err_clr     (err_clr[i]),
      .count       (count[i*CW +: CW]),
      .full        (full[i]),
      .empty       (empty[i]),
      .almost_full (almost_full[i]),
      .almost_empty(almost_empty[i]),
      .ovf         (ovf[i]),
      .udf         (udf[i])
    );
  end
endmodule
